spi_master_core: RTL and testbench

Register bank plus SPI master engine sitting directly downstream of the AXI-lite register interface. Consumes its write data bus and the control/data write strobes, and returns the control, status and data register contents for AXI reads. Serialises one DATA_W-bit frame per data-register write onto SPI (all four CPOL/CPHA modes) and captures MISO into the receive register.

---
 rtl/spi_pkg.sv | 27 ++
 rtl/spi_master_core_sclk_gen.sv | 30 +++
 rtl/spi_master_core.sv | 204 ++++++++++++++++++++
 tb/tb_spi_master_core.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: constants and types shared by the SPI master register bank, its
// sub-modules and the AXI-lite front end.
//   - register offsets (control / status / data)
//   - control and status register bit positions
//   - FSM state encoding
package spi_pkg;

  localparam logic [7:0] REG_CTRL_OFS   = 8'h00;
  localparam logic [7:0] REG_STATUS_OFS = 8'h04;
  localparam logic [7:0] REG_DATA_OFS   = 8'h08;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_CPOL    = 1;
  localparam int unsigned CTRL_CPHA    = 2;
  localparam int unsigned CTRL_LSB     = 3;
  localparam int unsigned CTRL_DIV_LSB = 8;
  localparam int unsigned CTRL_CLR     = 31;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_TX_PEND = 1;
  localparam int unsigned ST_RX_VLD  = 2;
  localparam int unsigned ST_RX_OVR  = 3;
  localparam int unsigned ST_TX_OVF  = 4;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_e;

endpackage

// File: rtl/spi_master_core_sclk_gen.sv
// spi_sclk_gen: SCLK half-period timer.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_restart      : hold counter at zero (idle / abort / frame start)
//   i_div          : latched divider; one tick every i_div+1 clocks
//   o_tick         : high in the last clock of each half-period
module spi_sclk_gen #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == i_div);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_core.sv
// spi_master_core: control/status/data register bank plus SPI master engine.
//   FCLK_CLK0, RST_N           : system clock, async active-low reset
//   i_data_to_registers        : AXI write data
//   i_wr_controll_reg          : control register write strobe
//   i_wr_data_reg              : data register write strobe (queues a frame)
//   o_controll_reg             : control readback (CLR always reads 0)
//   o_status_reg               : {tx_overflow, rx_overrun, rx_valid, tx_pending, busy}
//   o_data_reg                 : last received frame, zero-extended
//   o_spi_sclk/mosi/cs_n, i_spi_miso : SPI pins (MISO pre-synchronised)
module spi_master_core
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic        FCLK_CLK0,
  input  logic        RST_N,
  input  logic [31:0] i_data_to_registers,
  input  logic        i_wr_controll_reg,
  input  logic        i_wr_data_reg,
  output logic [31:0] o_controll_reg,
  output logic [31:0] o_status_reg,
  output logic [31:0] o_data_reg,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso,
  output logic        o_spi_cs_n
);

  localparam int unsigned EDGE_W = $clog2(2 * DATA_W);

  spi_state_e        r_state;
  logic [31:0]       r_ctrl;
  logic              r_cpol, r_cpha, r_lsb;
  logic [DIV_W-1:0]  r_div;
  logic [DATA_W-1:0] r_tx, r_rx_sh, r_rx, r_hold;
  logic [EDGE_W-1:0] r_edge;
  logic              r_pend, r_rx_valid, r_rx_ovr, r_tx_ovf;
  logic              r_sclk, r_mosi, r_cs_n;

  logic [31:0]       w_ctrl_mask, w_ctrl_next;
  logic              w_en, w_clr, w_tick, w_abort, w_restart, w_start, w_have_word;
  logic              w_lead, w_sample, w_shift, w_last;
  logic [DATA_W-1:0] w_src_word, w_tx_shift, w_miso_vec, w_rx_in, w_rx_fin;

  function automatic logic sel_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  // Control write is resolved first so the FSM sees the new EN/mode this cycle.
  always_comb begin
    w_ctrl_mask                          = '0;
    w_ctrl_mask[CTRL_EN]                 = 1'b1;
    w_ctrl_mask[CTRL_CPOL]               = 1'b1;
    w_ctrl_mask[CTRL_CPHA]               = 1'b1;
    w_ctrl_mask[CTRL_LSB]                = 1'b1;
    w_ctrl_mask[CTRL_DIV_LSB +: DIV_W]   = '1;
    w_ctrl_next = i_wr_controll_reg ? (i_data_to_registers & w_ctrl_mask) : r_ctrl;
    w_en        = w_ctrl_next[CTRL_EN];
    w_clr       = i_wr_controll_reg & i_data_to_registers[CTRL_CLR];
  end

  assign w_abort     = (r_state != IDLE) && !w_en;
  assign w_restart   = (r_state == IDLE) || w_abort;
  assign w_have_word = r_pend || i_wr_data_reg;
  assign w_src_word  = r_pend ? r_hold : i_data_to_registers[DATA_W-1:0];
  assign w_start     = w_en && w_have_word &&
                       ((r_state == IDLE) || ((r_state == HOLD) && w_tick));

  // Edges are numbered from 0; even edges are leading. With CPHA=1 the first
  // bit is already on MOSI from SETUP, so the first leading edge does not shift.
  always_comb begin
    w_lead     = ~r_edge[0];
    w_sample   = r_cpha ? ~w_lead : w_lead;
    w_shift    = r_cpha ? (w_lead && (r_edge != '0)) : ~w_lead;
    w_last     = (r_edge == EDGE_W'(2 * DATA_W - 1));
    w_tx_shift = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    w_miso_vec    = '0;
    w_miso_vec[0] = i_spi_miso;
    w_rx_in    = r_lsb ? ((r_rx_sh >> 1) | (w_miso_vec << (DATA_W - 1)))
                       : ((r_rx_sh << 1) | w_miso_vec);
    w_rx_fin   = w_sample ? w_rx_in : r_rx_sh;
  end

  spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
    .i_clk     (FCLK_CLK0),
    .i_rst_n   (RST_N),
    .i_restart (w_restart),
    .i_div     (r_div),
    .o_tick    (w_tick)
  );

  always_ff @(posedge FCLK_CLK0 or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_ctrl     <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsb      <= 1'b0;
      r_div      <= '0;
      r_tx       <= '0;
      r_rx_sh    <= '0;
      r_rx       <= '0;
      r_hold     <= '0;
      r_edge     <= '0;
      r_pend     <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_tx_ovf   <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_ctrl <= w_ctrl_next;

      if (w_clr) begin
        r_rx_valid <= 1'b0;
        r_rx_ovr   <= 1'b0;
        r_tx_ovf   <= 1'b0;
      end
      if (i_wr_data_reg && r_pend) r_tx_ovf <= 1'b1;

      // Holding register: a write is parked unless it is consumed by a start.
      if (i_wr_data_reg && !r_pend && !w_start) begin
        r_pend <= 1'b1;
        r_hold <= i_data_to_registers[DATA_W-1:0];
      end else if (w_abort || (w_start && r_pend)) begin
        r_pend <= 1'b0;
      end

      if (w_abort) begin
        r_state <= IDLE;
        r_cs_n  <= 1'b1;
        r_sclk  <= w_ctrl_next[CTRL_CPOL];
        r_mosi  <= 1'b0;
      end else if (w_start) begin
        r_state <= SETUP;
        r_cs_n  <= 1'b0;
        r_cpol  <= w_ctrl_next[CTRL_CPOL];
        r_cpha  <= w_ctrl_next[CTRL_CPHA];
        r_lsb   <= w_ctrl_next[CTRL_LSB];
        r_div   <= w_ctrl_next[CTRL_DIV_LSB +: DIV_W];
        r_sclk  <= w_ctrl_next[CTRL_CPOL];
        r_tx    <= w_src_word;
        r_mosi  <= sel_bit(w_src_word, w_ctrl_next[CTRL_LSB]);
        r_rx_sh <= '0;
        r_edge  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cs_n <= 1'b1;
            r_sclk <= w_ctrl_next[CTRL_CPOL];
            r_mosi <= 1'b0;
          end
          SETUP: begin
            if (w_tick) r_state <= XFER;
          end
          XFER: begin
            if (w_tick) begin
              r_sclk <= ~r_sclk;
              r_edge <= r_edge + EDGE_W'(1);
              if (w_sample) r_rx_sh <= w_rx_in;
              if (w_shift) begin
                r_tx   <= w_tx_shift;
                r_mosi <= sel_bit(w_tx_shift, r_lsb);
              end
              if (w_last) begin
                r_state <= HOLD;
                r_rx    <= w_rx_fin;
                if (r_rx_valid) r_rx_ovr   <= 1'b1;
                else            r_rx_valid <= 1'b1;
              end
            end
          end
          HOLD: begin
            if (w_tick) begin
              r_state <= IDLE;
              r_cs_n  <= 1'b1;
              r_mosi  <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    o_status_reg             = '0;
    o_status_reg[ST_BUSY]    = (r_state != IDLE);
    o_status_reg[ST_TX_PEND] = r_pend;
    o_status_reg[ST_RX_VLD]  = r_rx_valid;
    o_status_reg[ST_RX_OVR]  = r_rx_ovr;
    o_status_reg[ST_TX_OVF]  = r_tx_ovf;
    o_data_reg               = '0;
    o_data_reg[DATA_W-1:0]   = r_rx;
  end

  assign o_controll_reg = r_ctrl;
  assign o_spi_sclk     = r_sclk;
  assign o_spi_mosi     = r_mosi;
  assign o_spi_cs_n     = r_cs_n;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed testbench for spi_master_core (DATA_W=8, DIV_W=8).
module tb_spi_master_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wdata = '0;
  logic        wr_ctrl = 1'b0, wr_data = 1'b0;
  logic [31:0] ctrl_rb, status_rb, data_rb;
  logic        spi_sclk, spi_mosi, spi_cs_n, spi_miso;
  logic        miso_loop = 1'b0, miso_tie = 1'b0;

  int          n_tests = 0;
  int          n_fail  = 0;

  int          cs_low, edges, hmin, hmax, rises;
  logic [31:0] seen;
  logic        done, prev;

  always #5 clk = ~clk;

  assign spi_miso = miso_loop ? spi_mosi : miso_tie;

  spi_master_core #(.DATA_W(8), .DIV_W(8)) dut (
    .FCLK_CLK0           (clk),
    .RST_N               (rst_n),
    .i_data_to_registers (wdata),
    .i_wr_controll_reg   (wr_ctrl),
    .i_wr_data_reg       (wr_data),
    .o_controll_reg      (ctrl_rb),
    .o_status_reg        (status_rb),
    .o_data_reg          (data_rb),
    .o_spi_sclk          (spi_sclk),
    .o_spi_mosi          (spi_mosi),
    .i_spi_miso          (spi_miso),
    .o_spi_cs_n          (spi_cs_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_ctrl(input logic [31:0] v);
    wdata = v; wr_ctrl = 1'b1;
    @(posedge clk); #1;
    wr_ctrl = 1'b0;
  endtask

  task automatic write_data(input logic [31:0] v);
    wdata = v; wr_data = 1'b1;
    @(posedge clk); #1;
    wr_data = 1'b0;
  endtask

  // Observes one cs_n-low window, one sample per clock, until cs_n rises.
  // MOSI is captured at the slave's sampling edge (leading for CPHA=0).
  task automatic run_frame(input logic idle_sclk, input logic cpha, input int budget,
                           output int o_cs_low, output int o_edges, output int o_hmin,
                           output int o_hmax, output logic [31:0] o_seen, output logic o_done);
    logic p;
    int   last_t;
    p = idle_sclk; o_cs_low = 0; o_edges = 0; o_hmin = 1000; o_hmax = 0;
    o_seen = '0; o_done = 1'b0; last_t = 0;
    for (int cyc = 0; cyc < budget && !o_done; cyc++) begin
      if (spi_cs_n == 1'b0) o_cs_low++;
      if (spi_sclk != p) begin
        if (o_edges > 0) begin
          if (cyc - last_t < o_hmin) o_hmin = cyc - last_t;
          if (cyc - last_t > o_hmax) o_hmax = cyc - last_t;
        end
        last_t = cyc;
        o_edges++;
        if (((o_edges % 2) == 1) != cpha) o_seen = {o_seen[30:0], spi_mosi};
        p = spi_sclk;
      end
      if (spi_cs_n && o_cs_low > 0) o_done = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl",   ctrl_rb,   32'h0);
    check("rst_status", status_rb, 32'h0);
    check("rst_data",   data_rb,   32'h0);
    check("rst_cs_n",   32'(spi_cs_n), 32'h1);
    check("rst_sclk",   32'(spi_sclk), 32'h0);
    check("rst_mosi",   32'(spi_mosi), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: mode 0, DIV=0, 0xA5 with MISO looped back
    miso_loop = 1'b1;
    write_ctrl(32'h0000_0001);
    check("t1_ctrl", ctrl_rb, 32'h1);
    write_data(32'h0000_00A5);
    check("t1_cs_low0", 32'(spi_cs_n), 32'h0);
    check("t1_mosi0",   32'(spi_mosi), 32'h1);
    run_frame(1'b0, 1'b0, 100, cs_low, edges, hmin, hmax, seen, done);
    check("t1_done",   32'(done), 32'h1);
    check("t1_cs_len", cs_low, 18);
    check("t1_edges",  edges, 16);
    check("t1_hmin",   hmin, 1);
    check("t1_hmax",   hmax, 1);
    check("t1_mosi",   seen, 32'h0000_00A5);
    check("t1_status", status_rb, 32'h4);
    check("t1_data",   data_rb, 32'h0000_00A5);

    // 2: CPOL=1 CPHA=1 LSB first DIV=3, MISO tied high (CLR drops old rx_valid)
    miso_loop = 1'b0; miso_tie = 1'b1;
    write_ctrl(32'h8000_030F);
    check("t2_ctrl",   ctrl_rb, 32'h0000_030F);
    check("t2_status_clr", status_rb, 32'h0);
    check("t2_idle_sclk", 32'(spi_sclk), 32'h1);
    write_data(32'h0000_0001);
    check("t2_mosi0",  32'(spi_mosi), 32'h1);
    run_frame(1'b1, 1'b1, 300, cs_low, edges, hmin, hmax, seen, done);
    check("t2_done",   32'(done), 32'h1);
    check("t2_cs_len", cs_low, 72);
    check("t2_edges",  edges, 16);
    check("t2_hmin",   hmin, 4);
    check("t2_hmax",   hmax, 4);
    check("t2_mosi",   seen, 32'h0000_0080);
    check("t2_sclk_end", 32'(spi_sclk), 32'h1);
    check("t2_status", status_rb, 32'h4);
    check("t2_data",   data_rb, 32'h0000_00FF);

    // 3: back-to-back frames, third write overflows
    miso_loop = 1'b1;
    write_ctrl(32'h8000_0001);
    write_data(32'h0000_0011);
    write_data(32'h0000_0022);
    write_data(32'h0000_0033);
    check("t3_status_busy", status_rb, 32'h13);
    run_frame(1'b0, 1'b0, 100, cs_low, edges, hmin, hmax, seen, done);
    check("t3_done",   32'(done), 32'h1);
    check("t3_cs_len", cs_low, 34);
    check("t3_edges",  edges, 32);
    check("t3_mosi",   seen, 32'h0000_1122);
    check("t3_status", status_rb, 32'h1C);
    check("t3_data",   data_rb, 32'h0000_0022);

    // 4: CLR
    write_ctrl(32'h8000_0001);
    check("t4_status", status_rb, 32'h0);
    check("t4_ctrl",   ctrl_rb, 32'h0000_0001);

    // 5: EN dropped while bit 4 is on the wire
    write_data(32'h0000_00F0);
    rises = 0; prev = 1'b0;
    for (int i = 0; i < 40 && rises < 5; i++) begin
      @(posedge clk); #1;
      if (spi_sclk && !prev) rises++;
      prev = spi_sclk;
    end
    check("t5_reach", rises, 5);
    check("t5_busy_before", status_rb, 32'h1);
    write_ctrl(32'h0000_0000);
    check("t5_cs_n",   32'(spi_cs_n), 32'h1);
    check("t5_sclk",   32'(spi_sclk), 32'h0);
    check("t5_status", status_rb, 32'h0);
    check("t5_data",   data_rb, 32'h0000_0022);
    repeat (20) @(posedge clk);
    #1;
    check("t5_cs_n_later", 32'(spi_cs_n), 32'h1);
    check("t5_data_later", data_rb, 32'h0000_0022);

    // 6: parked word starts on EN, then async reset mid-frame
    write_data(32'h0000_005A);
    check("t6_pending", status_rb, 32'h2);
    check("t6_cs_idle", 32'(spi_cs_n), 32'h1);
    write_ctrl(32'h0000_0001);
    check("t6_started", status_rb, 32'h1);
    check("t6_cs_low",  32'(spi_cs_n), 32'h0);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_cs_n",   32'(spi_cs_n), 32'h1);
    check("t6_sclk",   32'(spi_sclk), 32'h0);
    check("t6_mosi",   32'(spi_mosi), 32'h0);
    check("t6_ctrl",   ctrl_rb, 32'h0);
    check("t6_status", status_rb, 32'h0);
    check("t6_data",   data_rb, 32'h0);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
